biquad8_coeff_loader: RTL



---
 rtl/biquad8_coeff_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader: shadows low/high B1 coefficients and, on commit,
// walks the biquad through B1 load, cascade transfer and B2 update.
module biquad8_coeff_loader #(
  parameter int                     NBITS_COEFF  = 18,
  parameter logic [NBITS_COEFF-1:0] DEFAULT_LOW  = '0,
  parameter logic [NBITS_COEFF-1:0] DEFAULT_HIGH = '0,
  parameter int                     CNT_BITS     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_wr_i,
  input  logic [1:0]             cfg_adr_i,
  input  logic [NBITS_COEFF-1:0] cfg_dat_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_BITS-1:0]    commit_count_o,
  output logic                   coeff_adr_o,
  output logic                   coeff_wr_o,
  output logic                   coeff_update_o,
  output logic [NBITS_COEFF-1:0] coeff_dat_o
);

  typedef enum logic [3:0] {
    IDLE,
    HI_LD,
    HI_LD_H,
    HI_XF,
    HI_XF_H,
    LO_LD,
    LO_LD_H,
    UPD,
    DONE
  } state_t;

  state_t                 state;
  logic                   pending;
  logic [NBITS_COEFF-1:0] sh_lo;
  logic [NBITS_COEFF-1:0] sh_hi;
  logic [NBITS_COEFF-1:0] wk_lo;
  logic [NBITS_COEFF-1:0] wk_hi;
  logic                   commit;
  logic                   start;

  assign commit = cfg_wr_i && (cfg_adr_i == 2'd2);

  // A new sequence begins from IDLE on commit, or from DONE when one is queued.
  always_comb begin
    start = 1'b0;
    if (state == IDLE)
      start = commit;
    else if (state == DONE)
      start = commit || pending;
  end

  // Shadow registers take bus writes at any time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_lo <= DEFAULT_LOW;
      sh_hi <= DEFAULT_HIGH;
    end else if (cfg_wr_i) begin
      if (cfg_adr_i == 2'd0)
        sh_lo <= cfg_dat_i;
      else if (cfg_adr_i == 2'd1)
        sh_hi <= cfg_dat_i;
    end
  end

  // Sequencer: each output is registered from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      pending        <= 1'b0;
      wk_lo          <= DEFAULT_LOW;
      wk_hi          <= DEFAULT_HIGH;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      commit_count_o <= '0;
      coeff_adr_o    <= 1'b0;
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
      coeff_dat_o    <= '0;
    end else begin
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
      done_o         <= 1'b0;
      if (commit && busy_o)
        pending <= 1'b1;
      if (start) begin
        state       <= HI_LD;
        pending     <= 1'b0;
        wk_lo       <= sh_lo;
        wk_hi       <= sh_hi;
        busy_o      <= 1'b1;
        coeff_dat_o <= sh_hi;
        coeff_adr_o <= 1'b0;
        coeff_wr_o  <= 1'b1;
      end else begin
        unique case (state)
          IDLE: state <= IDLE;
          HI_LD: state <= HI_LD_H;
          HI_LD_H: begin
            state       <= HI_XF;
            coeff_adr_o <= 1'b1;
            coeff_wr_o  <= 1'b1;
          end
          HI_XF: state <= HI_XF_H;
          HI_XF_H: begin
            state       <= LO_LD;
            coeff_adr_o <= 1'b0;
            coeff_wr_o  <= 1'b1;
            coeff_dat_o <= wk_lo;
          end
          LO_LD: state <= LO_LD_H;
          LO_LD_H: begin
            state          <= UPD;
            coeff_update_o <= 1'b1;
          end
          UPD: begin
            state          <= DONE;
            busy_o         <= 1'b0;
            done_o         <= 1'b1;
            commit_count_o <= commit_count_o + CNT_BITS'(1);
          end
          DONE: state <= IDLE;
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

  logic unused_wk_hi;
  assign unused_wk_hi = ^wk_hi;

endmodule
